dokmean_mul_pipe: RTL and testbench

Parametrised, pipelined mixed-sign multiplier with valid/ready flow control, per-result overflow flag and a saturating overflow event counter. It succeeds the single-cycle combinational truncating multiplier in the doKmean distance/centroid datapath. Operand widths, signedness, result width and pipeline depth are configurable, so one block serves every product in the kernel at the target clock.

---
 rtl/dokmean_mul_pkg.sv | 21 ++
 rtl/dokmean_mul_sat.sv | 45 ++++
 rtl/dokmean_mul_pipe.sv | 133 +++++++++++++
 tb/tb_dokmean_mul_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dokmean_mul_pkg.sv
// Shared constants and width helpers for the doKmean pipelined multiplier.
// Optional clamping build: DOKMEAN_MUL_SAT_EN (tested only in dokmean_mul_sat).
package dokmean_mul_pkg;

    localparam int OVF_CNT_W = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 16'hFFFF;

    // Exact signed product width after one-bit extension of each operand.
    function automatic int full_width(input int aw, input int bw);
        return aw + bw + 2;
    endfunction

    function automatic longint smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/dokmean_mul_sat.sv
// Overflow detect and truncate/clamp of the exact product to P_WIDTH signed.
// DOKMEAN_MUL_SAT_EN defined: overflowing products clamp; otherwise they truncate.
module dokmean_mul_sat
    import dokmean_mul_pkg::*;
#(
    parameter int FW      = 20,
    parameter int P_WIDTH = 11
) (
    input  logic signed [FW-1:0]      prod,
    output logic        [P_WIDTH-1:0] p,
    output logic                      ovf
);

    localparam longint PMAX_L = smax(P_WIDTH);
    localparam longint PMIN_L = smin(P_WIDTH);
    localparam logic [P_WIDTH-1:0] PMAX_P = PMAX_L[P_WIDTH-1:0];
    localparam logic [P_WIDTH-1:0] PMIN_P = PMIN_L[P_WIDTH-1:0];

    longint             prod_x_s;
    logic [P_WIDTH-1:0] trunc_s;

    // Compare in 64 bits so the result width may exceed the product width.
    assign prod_x_s = longint'(prod);
    assign ovf      = (prod_x_s > PMAX_L) || (prod_x_s < PMIN_L);
    assign trunc_s  = prod_x_s[P_WIDTH-1:0];

`ifdef DOKMEAN_MUL_SAT_EN
    // Clamp toward the sign of the exact product when it does not fit.
    always_comb begin
        p = trunc_s;
        if (ovf) begin
            if (prod_x_s < 64'sd0) begin
                p = PMIN_P;
            end else begin
                p = PMAX_P;
            end
        end else begin
            p = trunc_s;
        end
    end
`else
    assign p = trunc_s;
`endif

endmodule

// File: rtl/dokmean_mul_pipe.sv
// Pipelined mixed-sign multiplier with valid/ready stall, overflow flag and
// saturating overflow counter; clamping build selected by DOKMEAN_MUL_SAT_EN.
module dokmean_mul_pipe
    import dokmean_mul_pkg::*;
#(
    parameter int A_WIDTH   = 7,
    parameter int A_SIGNED  = 0,
    parameter int B_WIDTH   = 11,
    parameter int B_SIGNED  = 1,
    parameter int P_WIDTH   = 11,
    parameter int NUM_STAGE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [P_WIDTH-1:0]   p,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    input  logic                 ovf_clr
);

    localparam int FW = full_width(A_WIDTH, B_WIDTH);
    // Result stages after the multiply; with one stage the operands are not registered.
    localparam int RS = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    logic                  ce_s;
    logic [A_WIDTH-1:0]    mul_a_s;
    logic [B_WIDTH-1:0]    mul_b_s;
    logic                  mul_v_s;
    logic                  sign_a_s;
    logic                  sign_b_s;
    logic signed [FW-1:0]  a_x_s;
    logic signed [FW-1:0]  b_x_s;
    logic signed [FW-1:0]  prod_s;
    logic [P_WIDTH-1:0]    sat_p_s;
    logic                  sat_ovf_s;

    logic [P_WIDTH-1:0]    p_pipe_r   [RS];
    logic                  ovf_pipe_r [RS];
    logic                  v_pipe_r   [RS];
    logic [OVF_CNT_W-1:0]  cnt_r;

    assign ce_s     = !out_valid || out_ready;
    assign in_ready = ce_s;

    generate
        if (NUM_STAGE > 1) begin : g_op_stage
            logic [A_WIDTH-1:0] a_r;
            logic [B_WIDTH-1:0] b_r;
            logic               v_r;

            // Operand register stage; holds with the rest of the pipe on stall.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_r <= '0;
                    b_r <= '0;
                    v_r <= 1'b0;
                end else if (ce_s) begin
                    a_r <= a;
                    b_r <= b;
                    v_r <= in_valid;
                end
            end

            assign mul_a_s = a_r;
            assign mul_b_s = b_r;
            assign mul_v_s = v_r;
        end else begin : g_no_op_stage
            assign mul_a_s = a;
            assign mul_b_s = b;
            assign mul_v_s = in_valid;
        end
    endgenerate

    // Extending both operands to the full width keeps the low FW bits exact.
    assign sign_a_s = (A_SIGNED != 0) ? mul_a_s[A_WIDTH-1] : 1'b0;
    assign sign_b_s = (B_SIGNED != 0) ? mul_b_s[B_WIDTH-1] : 1'b0;
    assign a_x_s    = {{(FW-A_WIDTH){sign_a_s}}, mul_a_s};
    assign b_x_s    = {{(FW-B_WIDTH){sign_b_s}}, mul_b_s};
    assign prod_s   = a_x_s * b_x_s;

    dokmean_mul_sat #(
        .FW      (FW),
        .P_WIDTH (P_WIDTH)
    ) u_sat (
        .prod (prod_s),
        .p    (sat_p_s),
        .ovf  (sat_ovf_s)
    );

    // Result shift register; bubbles advance and hold exactly like beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS; i++) begin
                p_pipe_r[i]   <= '0;
                ovf_pipe_r[i] <= 1'b0;
                v_pipe_r[i]   <= 1'b0;
            end
        end else if (ce_s) begin
            p_pipe_r[0]   <= sat_p_s;
            ovf_pipe_r[0] <= sat_ovf_s;
            v_pipe_r[0]   <= mul_v_s;
            for (int i = 1; i < RS; i++) begin
                p_pipe_r[i]   <= p_pipe_r[i-1];
                ovf_pipe_r[i] <= ovf_pipe_r[i-1];
                v_pipe_r[i]   <= v_pipe_r[i-1];
            end
        end
    end

    assign p         = p_pipe_r[RS-1];
    assign ovf       = ovf_pipe_r[RS-1];
    assign out_valid = v_pipe_r[RS-1];

    // Overflow event counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (ovf_clr) begin
            cnt_r <= '0;
        end else if (out_valid && out_ready && ovf && (cnt_r != OVF_CNT_MAX)) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign ovf_cnt = cnt_r;

endmodule

// File: tb/tb_dokmean_mul_pipe.sv
// Scoreboard bench for dokmean_mul_pipe at default parameters.
module tb_dokmean_mul_pipe;

    logic        clk;
    logic        reset;
    logic [6:0]  a;
    logic [10:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] p;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ovf_cnt;
    logic        ovf_clr;

    typedef struct {
        logic [10:0] p;
        logic        ovf;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [15:0] model_cnt;
    logic [10:0] nx_p;
    logic        nx_ovf;
    bit          nx_lat;
    bit          hold_prev;
    logic [10:0] prev_p;
    logic        prev_ovf;

    dokmean_mul_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_cnt   (ovf_cnt),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference product for a 7-bit unsigned a and an 11-bit signed b.
    function automatic logic [11:0] model(input logic [6:0] av, input logic [10:0] bv);
        longint     pr;
        logic       o;
        logic [10:0] r;
        pr = longint'(av) * longint'($signed(bv));
        o  = (pr > 64'sd1023) || (pr < -64'sd1024);
        r  = pr[10:0];
`ifdef DOKMEAN_MUL_SAT_EN
        if (o) r = (pr < 64'sd0) ? 11'h400 : 11'h3FF;
`endif
        return {o, r};
    endfunction

    // Monitor: scoreboard pops on delivery, pushes on acceptance, stall checks.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            check_eq("ovf_cnt", ovf_cnt, model_cnt);
            if (hold_prev) begin
                check_eq("hold_p", p, prev_p);
                check_eq("hold_ovf", ovf, prev_ovf);
                check_eq("hold_vld", out_valid, 1);
            end
            if (out_valid && !out_ready) check_eq("stall_rdy", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("p", p, e.p);
                    check_eq("ovf", ovf, e.ovf);
                    if (e.lat) check_eq("latency", cyc - e.cyc, 3);
                    if (ovf_clr) model_cnt = 16'h0000;
                    else if (e.ovf && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
                end
            end else if (ovf_clr) begin
                model_cnt = 16'h0000;
            end
            hold_prev = out_valid && !out_ready;
            prev_p    = p;
            prev_ovf  = ovf;
            if (in_valid && in_ready) sb_q.push_back('{nx_p, nx_ovf, cyc, nx_lat});
        end
    end

    task automatic send(input logic [6:0] av, input logic [10:0] bv,
                        input logic [10:0] ep, input logic eo, input bit lat);
        int n;
        a = av; b = bv; nx_p = ep; nx_ovf = eo; nx_lat = lat;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendm(input logic [6:0] av, input logic [10:0] bv);
        logic [11:0] m;
        m = model(av, bv);
        send(av, bv, m[10:0], m[11], 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        n_tests = 0; n_fail = 0; cyc = 0; model_cnt = 16'h0000;
        hold_prev = 1'b0; prev_p = 11'h000; prev_ovf = 1'b0;
        nx_p = 11'h000; nx_ovf = 1'b0; nx_lat = 1'b0;
        reset = 1'b1; a = 7'd0; b = 11'd0; in_valid = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_vld", out_valid, 0);
        check_eq("rst_p", p, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_cnt", ovf_cnt, 0);
        check_eq("rst_rdy", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single small negative product with latency check.
        send(7'd5, 11'h7FD, 11'h7F1, 1'b0, 1'b1);
        drain();

        // Positive overflow: truncated or clamped depending on build.
`ifdef DOKMEAN_MUL_SAT_EN
        send(7'd127, 11'd1023, 11'h3FF, 1'b1, 1'b0);
`else
        send(7'd127, 11'd1023, 11'h381, 1'b1, 1'b0);
`endif
        drain();
        check_eq("cnt_one", ovf_cnt, 1);

        // Negative overflow lands on the minimum in both builds.
        send(7'd127, 11'h400, 11'h400, 1'b1, 1'b0);
        drain();

        // Back-to-back squares with a mid-stream consumer stall.
        fork
            begin
                for (int i = 0; i < 10; i++) sendm(7'(i), 11'(i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Mixed random beats.
        for (int i = 0; i < 40; i++) sendm(7'($urandom_range(0, 127)), 11'($urandom_range(0, 2047)));
        drain();

        // Counter saturation.
        for (int i = 0; i < 65540; i++) sendm(7'd127, 11'd1023);
        drain();
        check_eq("cnt_sat", ovf_cnt, 16'hFFFF);

        // Clear coinciding with an overflow delivery; pipe advances while out_ready low.
        out_ready = 1'b0;
        sendm(7'd127, 11'd1023);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("clr_arrive", out_valid, 1);
        ovf_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check_eq("cnt_clr", ovf_cnt, 0);
        drain();

        // Reset with beats in flight.
        sendm(7'd127, 11'd1023);
        drain();
        sendm(7'd3, 11'd4);
        sendm(7'd6, 11'd7);
        sendm(7'd127, 11'd1023);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_vld", out_valid, 0);
        check_eq("mid_rst_cnt", ovf_cnt, 0);
        check_eq("mid_rst_rdy", in_ready, 1);
        sb_q.delete();
        model_cnt = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        send(7'd9, 11'h7F8, 11'h7B8, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
